// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST repair-address table: table depth,
// derived counter/index widths and the lookup priority-encoder result type.
package mbist_pkg;

    // Number of repairable rows (spare rows) available to the table.
    localparam int BIST_ERR_LIMIT = 4;

    // entry_cnt must represent 0..BIST_ERR_LIMIT inclusive.
    localparam int BIST_CNT_WD = $clog2(BIST_ERR_LIMIT) + 1;

    // Index of a single entry; kept at least one bit wide for a 1-deep table.
    localparam int BIST_IDX_WD = (BIST_ERR_LIMIT > 1) ? $clog2(BIST_ERR_LIMIT) : 1;

    // Result of the lowest-index match search over all entries.
    typedef struct packed {
        logic                   hit;
        logic [BIST_IDX_WD-1:0] idx;
    } lkp_t;

endpackage

// File: rtl/mbist_repair_entry.sv
// One repair-table entry: a valid bit and a stored failing address, plus
// the two equality comparators used by capture (duplicate detection) and
// by functional lookup. The stored address is left untouched by clear.
module mbist_repair_entry
    import mbist_pkg::*;
#(
    parameter int BIST_ADDR_WD = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [BIST_ADDR_WD-1:0] cap_addr,
    input  logic [BIST_ADDR_WD-1:0] lk_addr,
    output logic                    valid,
    output logic                    cap_match,
    output logic                    lk_match
);

    logic [BIST_ADDR_WD-1:0] stored_addr;

    // Valid bit: cleared by rst or clear; set when this slot is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Address field: written on load only, never reset, so clear keeps it.
    always_ff @(posedge clk) begin
        if (load) begin
            stored_addr <= cap_addr;
        end
    end

    // Comparators only report a match against a live entry.
    always_comb begin
        cap_match = valid && (stored_addr == cap_addr);
        lk_match  = valid && (stored_addr == lk_addr);
    end

endmodule

// File: rtl/mbist_repair_addr.sv
// Repair-address table placed after the MBIST comparator. Captures each
// distinct correctable failing address (up to BIST_ERR_LIMIT) in fill
// order and, during functional access, remaps a stored failing address to
// spare row BIST_REPAIR_ADDR_START + entry index with one cycle of latency.
module mbist_repair_addr
    import mbist_pkg::*;
#(
    parameter int                      BIST_ADDR_WD           = 9,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START        = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END          = 9'h1F8,
    parameter logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = 9'h1FC,
    parameter int                      BIST_RAD_WD_I          = BIST_ADDR_WD,
    parameter int                      BIST_RAD_WD_O          = BIST_ADDR_WD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     error_correct,
    input  logic [BIST_ADDR_WD-1:0]  error_addr,
    input  logic                     addr_req,
    input  logic [BIST_RAD_WD_I-1:0] addr_in,
    output logic                     addr_vld,
    output logic [BIST_RAD_WD_O-1:0] addr_out,
    output logic                     addr_hit,
    output logic [BIST_CNT_WD-1:0]   entry_cnt,
    output logic                     table_full,
    output logic                     overflow
);

    // Elaboration-time sanity of the address map: the testable range must
    // be ordered and the spare rows must sit above it.
    if (BIST_ADDR_END < BIST_ADDR_START) begin : g_bad_range
        $error("mbist_repair_addr: BIST_ADDR_END below BIST_ADDR_START");
    end
    if (BIST_REPAIR_ADDR_START <= BIST_ADDR_END) begin : g_bad_spare
        $error("mbist_repair_addr: spare rows overlap the testable range");
    end

    // Lowest-index match wins; duplicates are never stored, so in practice
    // at most one bit of match is set.
    function automatic lkp_t prio_enc(input logic [BIST_ERR_LIMIT-1:0] match);
        lkp_t r;
        r.hit = |match;
        r.idx = '0;
        for (int i = BIST_ERR_LIMIT - 1; i >= 0; i--) begin
            if (match[i]) begin
                r.idx = BIST_IDX_WD'(i);
            end
        end
        return r;
    endfunction

    // Spare-row address for entry idx, modulo 2^BIST_RAD_WD_O.
    function automatic logic [BIST_RAD_WD_O-1:0] spare_row(input logic [BIST_IDX_WD-1:0] idx);
        return BIST_RAD_WD_O'(BIST_REPAIR_ADDR_START) + BIST_RAD_WD_O'(idx);
    endfunction

    logic [BIST_ERR_LIMIT-1:0] valid_vec;
    logic [BIST_ERR_LIMIT-1:0] cap_match_vec;
    logic [BIST_ERR_LIMIT-1:0] lk_match_vec;
    logic [BIST_ERR_LIMIT-1:0] load_vec;
    logic [BIST_ADDR_WD-1:0]   lk_addr;
    logic                      dup;
    logic                      cap_we;
    logic                      ovf_set;
    lkp_t                      lkp;
    logic [BIST_RAD_WD_O-1:0]  remap;

    logic                      addr_vld_p1;
    logic [BIST_RAD_WD_O-1:0]  addr_out_p1;
    logic                      addr_hit_p1;

    // Functional address is zero-extended or truncated to table width.
    assign lk_addr = BIST_ADDR_WD'(addr_in);

    // Entry array: slot i is loaded when a capture lands while entry_cnt == i.
    for (genvar i = 0; i < BIST_ERR_LIMIT; i++) begin : g_entry
        assign load_vec[i] = cap_we && (entry_cnt == BIST_CNT_WD'(i));

        mbist_repair_entry #(
            .BIST_ADDR_WD (BIST_ADDR_WD)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .load      (load_vec[i]),
            .cap_addr  (error_addr),
            .lk_addr   (lk_addr),
            .valid     (valid_vec[i]),
            .cap_match (cap_match_vec[i]),
            .lk_match  (lk_match_vec[i])
        );
    end

    // Capture decision: duplicates are ignored, a new address either takes
    // the next free slot or flags overflow. clear suppresses both.
    always_comb begin
        table_full = (entry_cnt == BIST_CNT_WD'(BIST_ERR_LIMIT));
        dup        = |cap_match_vec;
        cap_we     = error_correct && !clear && !dup && !table_full;
        ovf_set    = error_correct && !clear && !dup && table_full;
    end

    // Fill pointer / entry count tracks how many slots hold valid entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_cnt <= '0;
        end else if (clear) begin
            entry_cnt <= '0;
        end else if (cap_we) begin
            entry_cnt <= entry_cnt + BIST_CNT_WD'(1);
        end
    end

    // Sticky overflow: held until clear or rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end
    end

    // Lookup against the pre-edge table; a miss passes the address through.
    always_comb begin
        lkp   = prio_enc(lk_match_vec);
        remap = lkp.hit ? spare_row(lkp.idx) : BIST_RAD_WD_O'(addr_in);
    end

    // ---- stage p1: registered lookup result ----
    // Output register; rst discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_vld_p1 <= 1'b0;
            addr_out_p1 <= '0;
            addr_hit_p1 <= 1'b0;
        end else begin
            addr_vld_p1 <= addr_req;
            if (addr_req) begin
                addr_out_p1 <= remap;
                addr_hit_p1 <= lkp.hit;
            end
        end
    end

    assign addr_vld = addr_vld_p1;
    assign addr_out = addr_out_p1;
    assign addr_hit = addr_hit_p1;

endmodule

// File: tb/tb_mbist_repair_addr.sv
// Scoreboard bench for mbist_repair_addr: the stimulus side updates a
// queue-based reference table and pushes expected lookup results; a
// separate monitor compares every cycle's outputs against it.
module tb_mbist_repair_addr;

    localparam int         LIMIT     = 4;
    localparam logic [8:0] REP_START = 9'h1FC;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       error_correct;
    logic [8:0] error_addr;
    logic       addr_req;
    logic [8:0] addr_in;
    logic       addr_vld;
    logic [8:0] addr_out;
    logic       addr_hit;
    logic [2:0] entry_cnt;
    logic       table_full;
    logic       overflow;

    always #5 clk = ~clk;

    mbist_repair_addr dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .error_correct (error_correct),
        .error_addr    (error_addr),
        .addr_req      (addr_req),
        .addr_in       (addr_in),
        .addr_vld      (addr_vld),
        .addr_out      (addr_out),
        .addr_hit      (addr_hit),
        .entry_cnt     (entry_cnt),
        .table_full    (table_full),
        .overflow      (overflow)
    );

    // Reference model state.
    logic [8:0] tab[$];
    bit         m_ovf;
    bit         exp_vld;
    bit         exp_rst;
    logic [9:0] exp_q[$];   // {hit, addr}

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Expected lookup result from the table as it stands before the edge.
    task automatic push_lookup(input logic [8:0] a);
        int idx = -1;
        for (int i = 0; i < tab.size(); i++)
            if (idx < 0 && tab[i] == a) idx = i;
        if (idx >= 0) exp_q.push_back({1'b1, 9'(REP_START + 9'(idx))});
        else          exp_q.push_back({1'b0, a});
    endtask

    task automatic capture(input logic [8:0] a);
        bit found = 0;
        foreach (tab[i]) if (tab[i] == a) found = 1;
        if (!found) begin
            if (tab.size() < LIMIT) tab.push_back(a);
            else m_ovf = 1;
        end
    endtask

    // Drive one cycle of inputs on the falling edge and advance the model.
    task automatic drive(input bit r, input bit c, input bit ec, input logic [8:0] ea,
                         input bit rq, input logic [8:0] ai);
        @(negedge clk);
        rst = r; clear = c; error_correct = ec; error_addr = ea;
        addr_req = rq; addr_in = ai;
        exp_rst = r;
        exp_vld = rq && !r;
        if (rq && !r) push_lookup(ai);
        if (r) begin
            tab.delete(); m_ovf = 0;
        end else if (c) begin
            tab.delete(); m_ovf = 0;
        end else if (ec) begin
            capture(ea);
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 9'h000, 0, 9'h000);
    endtask

    // Monitor: compare outputs just after every rising edge.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            chk("addr_vld", 32'(addr_vld), 32'(exp_vld));
            chk("entry_cnt", 32'(entry_cnt), 32'(tab.size()));
            chk("table_full", 32'(table_full), 32'(tab.size() == LIMIT));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (exp_rst) begin
                chk("rst_addr_out", 32'(addr_out), 32'(0));
                chk("rst_addr_hit", 32'(addr_hit), 32'(0));
            end
            if (addr_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_vld actual=1 required=0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("addr_out", 32'(addr_out), 32'(e[8:0]));
                    chk("addr_hit", 32'(addr_hit), 32'(e[9]));
                end
            end
        end
    end

    initial begin
        logic [8:0] a, b;
        rst = 1; clear = 0; error_correct = 0; error_addr = '0;
        addr_req = 0; addr_in = '0;
        exp_rst = 1; exp_vld = 0; m_ovf = 0;

        // Reset.
        drive(1, 0, 0, 9'h000, 0, 9'h000);
        drive(1, 0, 0, 9'h000, 0, 9'h000);
        idle();

        // Duplicate capture is ignored.
        drive(0, 0, 1, 9'h010, 0, 9'h000);
        drive(0, 0, 1, 9'h020, 0, 9'h000);
        drive(0, 0, 1, 9'h010, 0, 9'h000);
        idle();

        // Fill to the limit, then overflow; lookup of the rejected address misses.
        drive(0, 1, 0, 9'h000, 0, 9'h000);
        for (int i = 1; i <= 5; i++) drive(0, 0, 1, 9'(i), 0, 9'h000);
        drive(0, 0, 0, 9'h000, 1, 9'h005);
        drive(0, 0, 0, 9'h000, 1, 9'h004);
        drive(0, 0, 0, 9'h000, 1, 9'h001);
        idle();

        // Spare-row remap, back-to-back lookups.
        drive(0, 1, 0, 9'h000, 0, 9'h000);
        drive(0, 0, 1, 9'h0A0, 0, 9'h000);
        drive(0, 0, 1, 9'h0B0, 0, 9'h000);
        drive(0, 0, 0, 9'h000, 1, 9'h0B0);
        drive(0, 0, 0, 9'h000, 1, 9'h0A0);
        drive(0, 0, 0, 9'h000, 1, 9'h0C0);
        idle();

        // Same-cycle capture and lookup sees the pre-edge table.
        drive(0, 1, 0, 9'h000, 0, 9'h000);
        drive(0, 0, 1, 9'h033, 1, 9'h033);
        drive(0, 0, 0, 9'h000, 1, 9'h033);
        idle();

        // Full with overflow, then clear together with a capture.
        drive(0, 0, 1, 9'h034, 0, 9'h000);
        drive(0, 0, 1, 9'h035, 0, 9'h000);
        drive(0, 0, 1, 9'h036, 0, 9'h000);
        drive(0, 0, 1, 9'h037, 0, 9'h000);
        drive(0, 1, 1, 9'h044, 1, 9'h036);   // lookup uses pre-clear table
        drive(0, 0, 0, 9'h000, 1, 9'h044);
        idle();

        // rst the cycle after a request, and rst alongside a request.
        drive(0, 0, 1, 9'h050, 0, 9'h000);
        drive(0, 0, 0, 9'h000, 1, 9'h050);
        drive(1, 0, 0, 9'h000, 0, 9'h000);
        idle();
        drive(0, 0, 1, 9'h060, 0, 9'h000);
        drive(1, 0, 0, 9'h000, 1, 9'h060);
        idle();

        // Randomized traffic over a small address pool so hits and duplicates occur.
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 11) << 4);
            b = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 11) << 4);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 1, a, $urandom_range(0, 1) == 1, b);
        end
        idle();
        idle();
        @(posedge clk);
        #2;
        chk("drain", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
